// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared widths, reset PC and halt opcode for the fetch unit
package instr_fetch_unit_pkg;

  localparam int          PC_W             = 16;
  localparam int          INSTR_W          = 16;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          OPCODE_W         = 4;
  localparam logic [3:0]  OP_HALT          = 4'hF;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - synchronous prefetch FIFO with flush, registered head
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is zeroed on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: PC generation, prefetch FIFO, redirect; IFU_HALT_EN adds halt opcode
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_W,
  parameter int                  INSTR_WIDTH = INSTR_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    imem_pc,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
`ifdef IFU_HALT_EN
  output logic                   halted,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]    out_pc
);

  localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [ENTRY_W-1:0]  head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                halt_q;
  logic                unused_bits;

  assign pop  = !fifo_empty && out_ready;
  assign push = !redirect_valid && !halt_q && (!fifo_full || pop);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({fetch_pc, imem_instruction}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign imem_pc                   = fetch_pc;
  assign out_valid                 = !fifo_empty;
  assign {out_pc, out_instruction} = head;
  assign unused_bits               = ^{fifo_count, redirect_pc[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[PC_WIDTH-1:1], 1'b0};
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_WIDTH'(2);
    end
  end

`ifdef IFU_HALT_EN
  // Halt is sampled on the pushed word, so the halt instruction itself still reaches decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (redirect_valid) begin
      halt_q <= 1'b0;
    end else if (push && is_halt(imem_instruction[INSTR_WIDTH-1 -: OPCODE_W])) begin
      halt_q <= 1'b1;
    end
  end
  assign halted = halt_q;
`else
  assign halt_q = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench: scoreboarded delivery order plus table of cycle checks
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_pc;
  logic [15:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instruction;
  logic [15:0] out_pc;
  logic        halt_rom = 1'b0;
`ifdef IFU_HALT_EN
  logic        halted;
`endif

  int total_checks = 0;
  int passed_checks = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  entry_t sb[$];

  typedef struct {
    logic        rst;
    logic        redir;
    logic [15:0] redir_pc;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_imem_pc;
    logic        chk_head;
    logic [15:0] exp_out_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  always_comb begin
    if (halt_rom && imem_pc == 16'h0006) imem_instruction = 16'hF000;
    else                                 imem_instruction = imem_pc ^ 16'hA5A5;
  end

  instr_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
`ifdef IFU_HALT_EN
    .halted           (halted),
`endif
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic entry_t mk(input logic [15:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = pc ^ 16'hA5A5;
    return e;
  endfunction

  // A transfer happening at the coming edge is scored against the scoreboard front.
  task automatic tick();
    entry_t e;
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {16'h0, out_pc}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("deliver_pc", {16'h0, out_pc}, {16'h0, e.pc});
        chk("deliver_instr", {16'h0, out_instruction}, {16'h0, e.instr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    out_ready = ready;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0041, 1'b0, 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0042, 1'b1, 16'h0040, 16'h0040 ^ 16'hA5A5};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0044, 1'b1, 16'h0040, 16'h0040 ^ 16'hA5A5};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0044, 1'b1, 16'h0040, 16'h0040 ^ 16'hA5A5};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0, 16'hFFFC, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'hFFFC, 16'hFFFC ^ 16'hA5A5};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'hFFFC, 16'hFFFC ^ 16'hA5A5};
    vecs[7] = '{1'b1, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA5A5};

    // Reset and steady-state streaming
    do_reset(1'b1);
    chk("reset_valid", out_valid, 0);
    chk("reset_imem_pc", imem_pc, 0);
    chk("reset_out_pc", out_pc, 0);
    chk("reset_out_instr", out_instruction, 0);
    tick();
    chk("first_valid_latency", out_valid, 1);
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'h0002));
    sb.push_back(mk(16'h0004));
    sb.push_back(mk(16'h0006));
    drain();

    // Back-pressure fills the FIFO and holds the fetch PC
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_imem_pc_hold", imem_pc, 16'h0004);
    chk("bp_head_pc", out_pc, 16'h0000);
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'h0002));
    sb.push_back(mk(16'h0004));
    drain();
    tick();
    chk("refill_full_valid", out_valid, 1);
    chk("refill_imem_pc", imem_pc, 16'h000A);

    // Redirects while full, odd target, wrap-around
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].redir_pc;
      out_ready = vecs[i].ready;
      tick();
      redirect_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_imem_pc", i), imem_pc, vecs[i].exp_imem_pc);
      if (vecs[i].chk_head) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_out_pc);
        chk($sformatf("vec%0d_out_instr", i), out_instruction, vecs[i].exp_instr);
      end
    end
    sb.push_back(mk(16'hFFFC));
    sb.push_back(mk(16'hFFFE));
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'h0002));
    drain();
    tick();
    chk("post_wrap_full", out_valid, 1);

    // Reset with a simultaneous redirect while full, then release
    for (int i = 7; i < 9; i++) begin
      rst = vecs[i].rst;
      redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].redir_pc;
      out_ready = vecs[i].ready;
      tick();
      redirect_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_imem_pc", i), imem_pc, vecs[i].exp_imem_pc);
      if (vecs[i].chk_head) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_out_pc);
        chk($sformatf("vec%0d_out_instr", i), out_instruction, vecs[i].exp_instr);
      end
    end

    // Opcode 4'hF at 0x0006
    halt_rom = 1'b1;
    do_reset(1'b1);
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'h0002));
    sb.push_back(mk(16'h0004));
    sb.push_back('{16'h0006, 16'hF000});
`ifdef IFU_HALT_EN
    drain();
    chk("halt_valid", out_valid, 0);
    chk("halt_flag", halted, 1);
    chk("halt_imem_pc", imem_pc, 16'h0008);
    tick();
    tick();
    chk("halt_hold_pc", imem_pc, 16'h0008);
    chk("halt_hold_valid", out_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    chk("unhalt_flag", halted, 0);
    chk("unhalt_imem_pc", imem_pc, 16'h0000);
    tick();
    chk("unhalt_valid", out_valid, 1);
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'h0002));
    drain();
`else
    sb.push_back(mk(16'h0008));
    drain();
    chk("no_halt_fetch_continues", out_valid, 1);
`endif
    halt_rom = 1'b0;

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
